// File: rtl/mem_fetch_ctrl.sv
// mem_fetch_ctrl: instruction fetch sequencer and store arbiter for the single-port 64x8 RAM.
// Optional MEM_WRITE_PROTECT_EN: stores below PROT_LIMIT are acked with wr_err and not written.
module mem_fetch_ctrl #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 8,
  parameter int INSTR_LEN  = 3,
  parameter int RESET_PC   = 0,
  parameter int PROT_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_opcode,
  output logic [DATA_W-1:0] instr_op1,
  output logic [DATA_W-1:0] instr_op2,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] pc,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              wr_err,
  output logic              fault,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_opcode,
  input  logic [DATA_W-1:0] ram_op1,
  input  logic [DATA_W-1:0] ram_op2
);
`ifdef MEM_WRITE_PROTECT_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif
  localparam logic [ADDR_W-1:0] PROT = ADDR_W'(PROT_LIMIT);
  localparam logic [ADDR_W:0] LAST_PC = (ADDR_W+1)'((1 << ADDR_W) - INSTR_LEN);
  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, HOLD, WRITE, FAULT} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] pc_n;
  logic vld_n, cap, prot_hit;
  assign prot_hit = PROT_EN && (wr_addr < PROT);
  assign wr_ack = state == WRITE;
  assign wr_err = wr_ack && prot_hit;
  assign ram_we = wr_ack && !prot_hit;
  assign ram_addr = wr_ack ? wr_addr : pc;
  assign ram_data = wr_ack ? wr_data : '0;
  always_comb begin
    state_n = state;
    pc_n = pc;
    vld_n = instr_valid;
    cap = 1'b0;
    case (state)
      IDLE:
        if (wr_req) state_n = WRITE;
        else if (jump_en) pc_n = jump_addr;
        else if (run) state_n = ({1'b0, pc} <= LAST_PC) ? FETCH : FAULT;
      FETCH: state_n = CAPTURE;
      CAPTURE: begin
        cap = 1'b1;
        pc_n = pc + ADDR_W'(INSTR_LEN);
        vld_n = 1'b1;
        state_n = HOLD;
      end
      HOLD:
        if (jump_en) begin
          pc_n = jump_addr;
          vld_n = 1'b0;
          state_n = IDLE;
        end else if (instr_ready) begin
          vld_n = 1'b0;
          state_n = IDLE;
        end else if (wr_req) state_n = WRITE;
      // fault is sticky, so a store taken from FAULT returns there
      WRITE: state_n = fault ? FAULT : instr_valid ? HOLD : IDLE;
      FAULT: if (wr_req) state_n = WRITE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc <= ADDR_W'(RESET_PC);
      instr_valid <= 1'b0;
      fault <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      instr_valid <= vld_n;
      fault <= fault | (state_n == FAULT);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_opcode <= '0;
      instr_op1 <= '0;
      instr_op2 <= '0;
      instr_pc <= '0;
    end else if (cap) begin
      instr_opcode <= ram_opcode;
      instr_op1 <= ram_op1;
      instr_op2 <= ram_op2;
      instr_pc <= pc;
    end
  end
endmodule

// File: tb/tb_mem_fetch_ctrl.sv
// tb_mem_fetch_ctrl: directed bench for mem_fetch_ctrl with a behavioural 64x8 registered-read RAM.
module tb_mem_fetch_ctrl;
  logic clk = 1'b0, rst = 1'b1, run = 1'b0, jump_en = 1'b0, instr_ready = 1'b0, wr_req = 1'b0;
  logic [5:0] jump_addr = '0, wr_addr = '0, instr_pc, pc, ram_addr;
  logic [7:0] wr_data = '0, instr_opcode, instr_op1, instr_op2, ram_data, ram_opcode, ram_op1, ram_op2;
  logic instr_valid, wr_ack, wr_err, fault, ram_we;
  logic [7:0] mem [64];
  int checks = 0, failures = 0;
`ifdef MEM_WRITE_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif
  mem_fetch_ctrl dut (
    .clk(clk), .rst(rst), .run(run), .jump_en(jump_en), .jump_addr(jump_addr),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_opcode(instr_opcode),
    .instr_op1(instr_op1), .instr_op2(instr_op2), .instr_pc(instr_pc), .pc(pc),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .wr_err(wr_err),
    .fault(fault), .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
    .ram_opcode(ram_opcode), .ram_op1(ram_op1), .ram_op2(ram_op2)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    ram_opcode <= mem[ram_addr];
    ram_op1 <= mem[ram_addr + 6'd1];
    ram_op2 <= mem[ram_addr + 6'd2];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    mem[0] = 8'h10; mem[1] = 8'h21; mem[2] = 8'h32;
    mem[3] = 8'h43; mem[4] = 8'h54; mem[5] = 8'h65;
    mem[6] = 8'h76; mem[7] = 8'h87; mem[8] = 8'h98;
    mem[61] = 8'ha1; mem[62] = 8'hb2; mem[63] = 8'hc3;
    #12;
    chk("rst_valid", instr_valid, 0);
    chk("rst_pc", pc, 0);
    chk("rst_fault", fault, 0);
    chk("rst_ack", wr_ack, 0);
    chk("rst_we", ram_we, 0);
    @(negedge clk);
    rst = 1'b0;
    run = 1'b1;
    step(1); chk("lat_e0_valid", instr_valid, 0);
    step(1); chk("lat_e1_valid", instr_valid, 0);
    step(1);
    chk("lat_e2_valid", instr_valid, 1);
    chk("i0_opcode", instr_opcode, 8'h10);
    chk("i0_op1", instr_op1, 8'h21);
    chk("i0_op2", instr_op2, 8'h32);
    chk("i0_pc", instr_pc, 0);
    chk("i0_nextpc", pc, 3);
    step(2);
    chk("hold_valid", instr_valid, 1);
    chk("hold_ramaddr", ram_addr, 3);
    chk("hold_we", ram_we, 0);
    wr_req = 1'b1; wr_addr = 6'd20; wr_data = 8'haa;
    step(1);
    chk("st_we", ram_we, 1);
    chk("st_addr", ram_addr, 20);
    chk("st_data", ram_data, 8'haa);
    chk("st_ack", wr_ack, 1);
    chk("st_err", wr_err, 0);
    chk("st_valid", instr_valid, 1);
    wr_req = 1'b0;
    step(1);
    chk("st_ack_end", wr_ack, 0);
    chk("st_valid_after", instr_valid, 1);
    chk("st_opcode_kept", instr_opcode, 8'h10);
    chk("st_mem20", mem[20], 8'haa);
    instr_ready = 1'b1;
    step(1); chk("b2b_drop", instr_valid, 0);
    step(3);
    chk("b2b1_valid", instr_valid, 1);
    chk("b2b1_pc", instr_pc, 3);
    chk("b2b1_op", instr_opcode, 8'h43);
    step(4);
    chk("b2b2_valid", instr_valid, 1);
    chk("b2b2_pc", instr_pc, 6);
    chk("b2b2_op", instr_opcode, 8'h76);
    jump_en = 1'b1; jump_addr = 6'd18;
    step(1);
    chk("jr_valid", instr_valid, 0);
    chk("jr_pc", pc, 18);
    jump_en = 1'b0; instr_ready = 1'b0;
    step(3);
    chk("j18_valid", instr_valid, 1);
    chk("j18_ipc", instr_pc, 18);
    chk("j18_op2", instr_op2, 8'haa);
    chk("j18_pc", pc, 21);
    jump_en = 1'b1; jump_addr = 6'd61;
    step(1);
    chk("j61_pc", pc, 61);
    chk("j61_valid", instr_valid, 0);
    jump_en = 1'b0;
    step(3);
    chk("j61_ipc", instr_pc, 61);
    chk("j61_op", instr_opcode, 8'ha1);
    chk("j61_op2", instr_op2, 8'hc3);
    chk("j61_wrap", pc, 0);
    jump_en = 1'b1; jump_addr = 6'd62;
    step(1);
    chk("j62_pc", pc, 62);
    jump_en = 1'b0;
    step(1);
    chk("flt_set", fault, 1);
    chk("flt_valid", instr_valid, 0);
    step(2);
    chk("flt_stay", fault, 1);
    chk("flt_valid2", instr_valid, 0);
    wr_req = 1'b1; wr_addr = 6'd30; wr_data = 8'h5a;
    step(1);
    chk("fst_ack", wr_ack, 1);
    chk("fst_we", ram_we, 1);
    chk("fst_fault", fault, 1);
    wr_req = 1'b0;
    step(1);
    chk("fst_ack_end", wr_ack, 0);
    chk("fst_fault2", fault, 1);
    chk("fst_mem30", mem[30], 8'h5a);
    wr_req = 1'b1; wr_addr = 6'd5; wr_data = 8'hee;
    step(1);
    chk("p5_ack", wr_ack, 1);
    chk("p5_err", wr_err, PROT ? 1 : 0);
    chk("p5_we", ram_we, PROT ? 0 : 1);
    wr_req = 1'b0;
    step(1);
    chk("p5_mem", mem[5], PROT ? 8'h65 : 8'hee);
    rst = 1'b1; run = 1'b0;
    #1;
    chk("rst2_fault", fault, 0);
    @(negedge clk);
    rst = 1'b0;
    jump_en = 1'b1; jump_addr = 6'd9;
    step(1);
    chk("j9_pc", pc, 9);
    jump_en = 1'b0; run = 1'b1;
    step(1);
    chk("fetch9_addr", ram_addr, 9);
    #2;
    wr_req = 1'b1; wr_addr = 6'd40; wr_data = 8'h11;
    rst = 1'b1;
    #1;
    chk("mid_pc", pc, 0);
    chk("mid_valid", instr_valid, 0);
    chk("mid_ack", wr_ack, 0);
    chk("mid_we", ram_we, 0);
    chk("mid_opcode", instr_opcode, 0);
    chk("mid_ipc", instr_pc, 0);
    wr_req = 1'b0; run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(1); chk("mid_noack1", wr_ack, 0);
    step(1); chk("mid_noack2", wr_ack, 0);
    chk("mid_mem40", mem[40], 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
